line_memory_responder: RTL and testbench

- Memory-side responder for the cache's 128-bit line interface.
- Accepts one `mem_read`/`mem_write` request at a time and models a slow main memory with a fixed, parameterised latency.
- Returns a one-cycle `mem_ready` pulse, with read data valid in the same cycle.
- Used as the backing store under the L1/L2 cache hierarchy in simulation and on FPGA.

---
 rtl/line_memory_responder.sv | 144 ++++++++++++++
 tb/tb_line_memory_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Slow main-memory model behind the 128-bit cache line interface: one request
// at a time, fixed LATENCY, single-cycle mem_ready completion pulse.
module line_memory_responder #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;

  state_t                  state_r, state_s;
  logic [7:0]              cnt_r, cnt_s;
  logic                    op_wr_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [DATA_W-1:0]       wdata_r;
  logic [DATA_W-1:0]       mem_rdata_r;
  logic                    mem_ready_r;
  logic                    proto_err_r;
  logic [15:0]             rd_count_r;
  logic [15:0]             wr_count_r;
  logic                    accept_s;
  logic                    enter_resp_s;
  logic                    rd_op_s;
  logic [DEPTH_LOG2-1:0]   rd_idx_s;
  logic                    wr_en_s;
  logic                    unused_addr_s;

  logic [DATA_W-1:0] mem_array [DEPTH];

  // Upper address bits alias onto the stored lines and are deliberately dropped.
  assign unused_addr_s = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  // Next-state, latency countdown and response-side decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    accept_s     = 1'b0;
    rd_op_s      = 1'b0;
    rd_idx_s     = idx_r;
    wr_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // With LATENCY=1 the read is fetched on the acceptance edge, so use the live address.
        rd_idx_s = mem_addr[DEPTH_LOG2-1:0];
        rd_op_s  = mem_read && !mem_write;
        if (mem_read || mem_write) begin
          accept_s = 1'b1;
          cnt_s    = LAT_M1;
          state_s  = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        rd_op_s = !op_wr_r;
        if (cnt_r == 8'd1) begin
          cnt_s   = 8'd0;
          state_s = ST_RESP;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      ST_RESP: begin
        wr_en_s = op_wr_r;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    enter_resp_s = (state_s == ST_RESP) && (state_r != ST_RESP);
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      op_wr_r     <= 1'b0;
      idx_r       <= {DEPTH_LOG2{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      mem_rdata_r <= {DATA_W{1'b0}};
      mem_ready_r <= 1'b0;
      proto_err_r <= 1'b0;
      rd_count_r  <= 16'd0;
      wr_count_r  <= 16'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mem_ready_r <= (state_s == ST_RESP);
      proto_err_r <= accept_s && mem_read && mem_write;
      if (accept_s) begin
        op_wr_r <= mem_write;
        idx_r   <= mem_addr[DEPTH_LOG2-1:0];
        wdata_r <= mem_wdata;
      end
      if (enter_resp_s && rd_op_s) begin
        mem_rdata_r <= mem_array[rd_idx_s];
      end
      if (state_r == ST_RESP) begin
        if (op_wr_r) begin
          wr_count_r <= wr_count_r + 16'd1;
        end else begin
          rd_count_r <= rd_count_r + 16'd1;
        end
      end
    end
  end

  // Line storage; never reset, so contents survive proc_reset_n.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_array[idx_r] <= wdata_r;
    end
  end

  assign mem_rdata = mem_rdata_r;
  assign mem_ready = mem_ready_r;
  assign proto_err = proto_err_r;
  assign rd_count  = rd_count_r;
  assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder: instance 0 at LATENCY=4,
// instance 1 at LATENCY=1, sharing clock and reset.
module tb_line_memory_responder;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         mem_read   [2];
  logic         mem_write  [2];
  logic [27:0]  mem_addr   [2];
  logic [127:0] mem_wdata  [2];
  logic [127:0] mem_rdata  [2];
  logic         mem_ready  [2];
  logic         proto_err  [2];
  logic [15:0]  rd_count   [2];
  logic [15:0]  wr_count   [2];

  typedef struct {
    int           d;
    int           ready_cyc;
    bit           is_read;
    logic [127:0] rdata;
  } sb_t;

  sb_t          sb [$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           exp_rd [2];
  int           exp_wr [2];
  int           proto_seen [2];
  logic [127:0] last_rd [2];

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D2 = 128'h0F0F0F0F_11112222_33334444_55556666;
  localparam logic [127:0] D3 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [127:0] D4 = 128'hAAAA5555_BBBB6666_CCCC7777_DDDD8888;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    line_memory_responder #(
      .ADDR_W(28), .DATA_W(128), .DEPTH_LOG2(10), .LATENCY((g == 0) ? 4 : 1)
    ) u_dut (
      .clk(clk), .proc_reset_n(proc_reset_n),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g]), .proto_err(proto_err[g]),
      .rd_count(rd_count[g]), .wr_count(wr_count[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every mem_ready pulse must match the oldest expected item.
  always @(negedge clk) begin : mon
    sb_t it;
    for (int d = 0; d < 2; d++) begin
      if (proto_err[d] === 1'b1) proto_seen[d]++;
      if (mem_ready[d] !== 1'b0) begin
        if (sb.size() == 0 || sb[0].d != d) begin
          check_val("unexpected_ready", {127'd0, mem_ready[d]}, 128'd0);
        end else begin
          it = sb.pop_front();
          check_val("latency", 128'(cyc), 128'(it.ready_cyc));
          if (it.is_read) begin
            check_val("rdata", mem_rdata[d], it.rdata);
            last_rd[d] = it.rdata;
          end else begin
            check_val("rdata_hold", mem_rdata[d], last_rd[d]);
          end
        end
      end
    end
  end

  // Drive one request at the current negedge, hold it until mem_ready, then drop it.
  task automatic do_req(input int d, input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] wd, input logic [127:0] exp_data, input int extra);
    sb_t e;
    bit  seen;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    mem_addr[d]  = a;
    mem_wdata[d] = wd;
    e.d         = d;
    e.ready_cyc = cyc + lat_of(d) + extra;
    e.is_read   = rd && !wr;
    e.rdata     = exp_data;
    sb.push_back(e);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (mem_ready[d] === 1'b1) seen = 1'b1;
    end
    check_val("ready_timeout", {127'd0, seen}, 128'd1);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    if (wr) exp_wr[d]++;
    else    exp_rd[d]++;
  endtask

  task automatic check_counts(input int d);
    logic [15:0] er, ew;
    @(negedge clk);
    er = exp_rd[d][15:0];
    ew = exp_wr[d][15:0];
    check_val("rd_count", {112'd0, rd_count[d]}, {112'd0, er});
    check_val("wr_count", {112'd0, wr_count[d]}, {112'd0, ew});
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pb;
    proc_reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      mem_addr[d] = 28'h0; mem_wdata[d] = 128'h0;
      exp_rd[d] = 0; exp_wr[d] = 0; proto_seen[d] = 0; last_rd[d] = 128'h0;
    end
    repeat (3) @(negedge clk);
    proc_reset_n = 1'b1;

    // Reset then idle: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        check_val("idle_quiet", {126'd0, mem_ready[d], proto_err[d]}, 128'd0);
    end
    check_val("reset_rdata0", mem_rdata[0], 128'h0);
    check_val("reset_rdata1", mem_rdata[1], 128'h0);
    check_counts(0);
    check_counts(1);

    // Write then read back at LATENCY=4.
    do_req(0, 1'b0, 1'b1, 28'h0000005, D1, 128'h0, 0);
    check_counts(0);
    do_req(0, 1'b1, 1'b0, 28'h0000005, 128'h0, D1, 0);
    check_counts(0);

    // Aliasing modulo 1024 lines.
    do_req(0, 1'b0, 1'b1, 28'h0000400, 128'h1, 128'h0, 0);
    check_counts(0);
    do_req(0, 1'b1, 1'b0, 28'h0000000, 128'h0, 128'h1, 0);
    check_counts(0);

    // Read and write together: write wins, proto_err pulses once.
    pb = proto_seen[0];
    do_req(0, 1'b1, 1'b1, 28'h0000007, 128'hA5, 128'h0, 0);
    check_counts(0);
    check_val("proto_pulses", 128'(proto_seen[0] - pb), 128'd1);
    do_req(0, 1'b1, 1'b0, 28'h0000007, 128'h0, 128'hA5, 0);
    check_counts(0);

    // Reset two cycles into a write: no response, no commit, counters cleared.
    do_req(0, 1'b0, 1'b1, 28'h0000009, 128'h1234, 128'h0, 0);
    check_counts(0);
    mem_write[0] = 1'b1; mem_addr[0] = 28'h0000009; mem_wdata[0] = 128'hFF;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b0;
    mem_write[0] = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_rd[d] = 0; exp_wr[d] = 0; last_rd[d] = 128'h0;
    end
    check_val("midreset_rdata", mem_rdata[0], 128'h0);
    check_counts(0);
    do_req(0, 1'b1, 1'b0, 28'h0000009, 128'h0, 128'h1234, 0);
    check_counts(0);

    // LATENCY=1: back-to-back write-back then fill, and read-after-write on one index.
    do_req(1, 1'b0, 1'b1, 28'h0000011, D3, 128'h0, 0);
    check_counts(1);
    do_req(1, 1'b0, 1'b1, 28'h0000003, D2, 128'h0, 0);
    do_req(1, 1'b1, 1'b0, 28'h0000011, 128'h0, D3, 1);
    check_counts(1);
    do_req(1, 1'b1, 1'b0, 28'h0000003, 128'h0, D2, 0);
    check_counts(1);
    do_req(1, 1'b0, 1'b1, 28'h0000020, D4, 128'h0, 0);
    do_req(1, 1'b1, 1'b0, 28'h0000020, 128'h0, D4, 1);
    check_counts(1);

    repeat (10) @(negedge clk);
    check_val("sb_empty", 128'(sb.size()), 128'd0);
    check_counts(0);
    check_counts(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
